// File: rtl/axil_master_access.sv
// AXI-Lite single-outstanding master: user cmd/rsp handshake to AW/W/B and AR/R.
// One transaction in flight; non-OKAY responses bump a saturating error counter.
module axil_master_access #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [STRB_WIDTH-1:0]    cmd_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    m_axil_awaddr,
  output logic [2:0]               m_axil_awprot,
  output logic                     m_axil_awvalid,
  input  logic                     m_axil_awready,
  output logic [DATA_WIDTH-1:0]    m_axil_wdata,
  output logic [STRB_WIDTH-1:0]    m_axil_wstrb,
  output logic                     m_axil_wvalid,
  input  logic                     m_axil_wready,
  input  logic [1:0]               m_axil_bresp,
  input  logic                     m_axil_bvalid,
  output logic                     m_axil_bready,
  output logic [ADDR_WIDTH-1:0]    m_axil_araddr,
  output logic [2:0]               m_axil_arprot,
  output logic                     m_axil_arvalid,
  input  logic                     m_axil_arready,
  input  logic [DATA_WIDTH-1:0]    m_axil_rdata,
  input  logic [1:0]               m_axil_rresp,
  input  logic                     m_axil_rvalid,
  output logic                     m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT_B,
    READ_AR,
    WAIT_R,
    RESP
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done;
  logic                    w_done;

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;

  // A channel counts as done if already retired or handshaking this cycle.
  assign aw_done = !m_axil_awvalid || m_axil_awready;
  assign w_done  = !m_axil_wvalid || m_axil_wready;

  function automatic logic [ERR_CNT_WIDTH-1:0] err_next(
    input logic [ERR_CNT_WIDTH-1:0] cnt,
    input logic [1:0]               resp
  );
    if (resp != 2'b00 && cnt != '1)
      return cnt + 1'b1;
    return cnt;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= 2'b00;
      err_count      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            if (cmd_write) begin
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= WRITE;
            end else begin
              m_axil_arvalid <= 1'b1;
              state          <= READ_AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (m_axil_awvalid && m_axil_awready)
            m_axil_awvalid <= 1'b0;
          if (m_axil_wvalid && m_axil_wready)
            m_axil_wvalid <= 1'b0;
          if (aw_done && w_done) begin
            m_axil_bready <= 1'b1;
            state         <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_write     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_resp      <= m_axil_bresp;
            err_count     <= err_next(err_count, m_axil_bresp);
            state         <= RESP;
          end
        end
        READ_AR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_write     <= 1'b0;
            rsp_rdata     <= m_axil_rdata;
            rsp_resp      <= m_axil_rresp;
            err_count     <= err_next(err_count, m_axil_rresp);
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_access.sv
// Directed bench for axil_master_access: behavioural AXI-Lite RAM slave
// with per-channel ready delays, and a response scoreboard queue.
module tb_axil_master_access;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = 4;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [EW-1:0] err_count;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  always #5 clk = ~clk;

  axil_master_access #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .err_count     (err_count),
    .m_axil_awaddr (awaddr),
    .m_axil_awprot (awprot),
    .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata  (wdata),
    .m_axil_wstrb  (wstrb),
    .m_axil_wvalid (wvalid),
    .m_axil_wready (wready),
    .m_axil_bresp  (bresp),
    .m_axil_bvalid (bvalid),
    .m_axil_bready (bready),
    .m_axil_araddr (araddr),
    .m_axil_arprot (arprot),
    .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata  (rdata),
    .m_axil_rresp  (rresp),
    .m_axil_rvalid (rvalid),
    .m_axil_rready (rready)
  );

  // ---------------- slave model ----------------
  int            aw_dly = 0;
  int            w_dly  = 0;
  int            ar_dly = 0;
  logic [1:0]    bresp_cfg = 2'b00;
  logic [1:0]    rresp_cfg = 2'b00;
  int            aw_cnt, w_cnt, ar_cnt;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_q;
  logic [DW-1:0] wd_q;
  logic [SW-1:0] ws_q;
  logic [DW-1:0] mem [0:31];
  logic          aw_hs, w_hs, aw_now, w_now;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_wd, merged;
  logic [SW-1:0] eff_ws;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old_w,
    input logic [DW-1:0] new_w,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < SW; i++)
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  assign awready  = !aw_got && (aw_cnt >= aw_dly);
  assign wready   = !w_got && (w_cnt >= w_dly);
  assign arready  = !rvalid && (ar_cnt >= ar_dly);
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign aw_now   = aw_got || aw_hs;
  assign w_now    = w_got || w_hs;
  assign eff_addr = aw_got ? aw_q : awaddr;
  assign eff_wd   = w_got ? wd_q : wdata;
  assign eff_ws   = w_got ? ws_q : wstrb;
  assign merged   = merge(mem[eff_addr], eff_wd, eff_ws);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_cnt <= 0;
      w_cnt  <= 0;
      ar_cnt <= 0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_q   <= '0;
      wd_q   <= '0;
      ws_q   <= '0;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_q   <= awaddr;
        aw_cnt <= 0;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (w_hs) begin
        w_got <= 1'b1;
        wd_q  <= wdata;
        ws_q  <= wstrb;
        w_cnt <= 0;
      end else if (wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (aw_now && w_now) begin
        aw_got         <= 1'b0;
        w_got          <= 1'b0;
        bvalid         <= 1'b1;
        bresp          <= bresp_cfg;
        mem[eff_addr]  <= merged;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= mem[araddr];
        rresp  <= rresp_cfg;
        ar_cnt <= 0;
      end else if (arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- bus monitor ----------------
  int            awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, bv_cyc = 0;
  int            aw_hs_n = 0, wd_chg = 0, viol = 0;
  logic          wv_prev = 1'b0;
  logic [DW-1:0] wd_prev = '0;

  always @(posedge clk) begin
    if (awvalid) awv_cyc <= awv_cyc + 1;
    if (wvalid)  wv_cyc  <= wv_cyc + 1;
    if (arvalid) arv_cyc <= arv_cyc + 1;
    if (bready)  bv_cyc  <= bv_cyc + 1;
    if (aw_hs)   aw_hs_n <= aw_hs_n + 1;
    if (wvalid && wv_prev && wdata !== wd_prev) wd_chg <= wd_chg + 1;
    if ((bready && (awvalid || wvalid || arvalid || rready)) ||
        (rready && (awvalid || wvalid || arvalid)))
      viol <= viol + 1;
    wv_prev <= wvalid;
    wd_prev <= wdata;
  end

  // ---------------- scoreboard & checks ----------------
  typedef struct {
    logic          wr;
    logic [DW-1:0] rd;
    logic [1:0]    resp;
    logic [EW-1:0] err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_err  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [DW-1:0] exp_rd,
                         input logic [1:0] exp_resp, input int hold);
    exp_t e;
    int   n;
    e.wr   = wr;
    e.rd   = wr ? '0 : exp_rd;
    e.resp = exp_resp;
    if (exp_resp != 2'b00 && exp_err < 255) exp_err++;
    e.err  = EW'(exp_err);
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = (hold == 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrive", 64'(rsp_valid), 64'd1);
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rdata", 64'(rsp_rdata), 64'(e.rd));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    chk("rsp_write", 64'(rsp_write), 64'(e.wr));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
    chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
    chk("err_count", 64'(err_count), 64'(e.err));
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  int b_aw, b_w, b_hs, b_chg, b_ar, b_b;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_addr", 64'({awaddr, araddr, wdata}), 64'd0);
    chk("prot", 64'({awprot, arprot}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // 1: immediate-ready write
    b_aw = awv_cyc; b_w = wv_cyc; b_b = bv_cyc;
    run_cmd(1'b1, 5'd1, 32'd2345, 4'hF, '0, 2'b00, 0);
    chk("s1_awvalid_cyc", 64'(awv_cyc - b_aw), 64'd1);
    chk("s1_wvalid_cyc", 64'(wv_cyc - b_w), 64'd1);
    chk("s1_bready_cyc", 64'(bv_cyc - b_b), 64'd1);

    // 2: wready lags awready by 3 cycles
    w_dly = 3;
    b_aw = awv_cyc; b_w = wv_cyc; b_hs = aw_hs_n; b_chg = wd_chg;
    run_cmd(1'b1, 5'd3, 32'hDEAD_BEEF, 4'hF, '0, 2'b00, 0);
    chk("s2_awvalid_cyc", 64'(awv_cyc - b_aw), 64'd1);
    chk("s2_wvalid_cyc", 64'(wv_cyc - b_w), 64'd4);
    chk("s2_aw_handshakes", 64'(aw_hs_n - b_hs), 64'd1);
    chk("s2_wdata_stable", 64'(wd_chg - b_chg), 64'd0);
    w_dly = 0;

    // 3: read back with delayed arready
    ar_dly = 2;
    b_ar = arv_cyc;
    run_cmd(1'b0, 5'd1, '0, '0, 32'd2345, 2'b00, 0);
    chk("s3_arvalid_cyc", 64'(arv_cyc - b_ar), 64'd3);
    ar_dly = 0;
    run_cmd(1'b0, 5'd3, '0, '0, 32'hDEAD_BEEF, 2'b00, 0);

    // 4: partial strobe write
    aw_dly = 2;
    run_cmd(1'b1, 5'd4, 32'h1234_5678, 4'hF, '0, 2'b00, 0);
    aw_dly = 0;
    run_cmd(1'b1, 5'd4, 32'hAAAA_5555, 4'b0011, '0, 2'b00, 0);
    run_cmd(1'b0, 5'd4, '0, '0, 32'h1234_5555, 2'b00, 0);

    // 5: error counter saturation
    bresp_cfg = 2'b10;
    for (int i = 0; i < 300; i++)
      run_cmd(1'b1, 5'd7, DW'(i), 4'hF, '0, 2'b10, 0);
    chk("s5_err_saturated", 64'(err_count), 64'd255);
    bresp_cfg = 2'b00;

    // 6: response back-pressure, then reset mid-WRITE
    run_cmd(1'b0, 5'd4, '0, '0, 32'h1234_5555, 2'b00, 5);
    aw_dly = 5;
    w_dly  = 5;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 5'd9;
    cmd_wdata = 32'h0BAD_F00D;
    cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("s6_in_write", 64'({awvalid, wvalid}), 64'b11);
    #2 rst = 1'b0;
    #1;
    chk("s6_rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    chk("s6_rst_cmd_rsp", 64'({cmd_ready, rsp_valid}), 64'd0);
    chk("s6_rst_err", 64'(err_count), 64'd0);
    exp_err = 0;
    aw_dly = 0;
    w_dly  = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("s6_cmd_ready_back", 64'(cmd_ready), 64'd1);
    rresp_cfg = 2'b10;
    run_cmd(1'b0, 5'd9, '0, '0, 32'd0, 2'b10, 0);
    rresp_cfg = 2'b00;
    run_cmd(1'b1, 5'd2, 32'hCAFE_0001, 4'b1000, '0, 2'b00, 0);
    run_cmd(1'b0, 5'd2, '0, '0, 32'hCA00_0000, 2'b00, 0);

    chk("channel_exclusive", 64'(viol), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
